// File: rtl/softmax_pkg.sv
// softmax_pkg: shared defaults, FSM state type and index-width helper for softmax_serializer
package softmax_pkg;
  localparam int DEF_NUM = 18;
  localparam int DEF_LEN = 16;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/softmax_serializer.sv
// softmax_serializer: captures a packed NUM-element vector and streams it out one element per handshake
// Ports: clk, rst (async active-high); in_valid/in_ready/in capture a NUM*LEN vector;
//        out_valid/out_ready handshake out_data, out_idx and out_last (element NUM-1).
// Optional SOFTMAX_SER_ARGMAX_EN adds argmax_idx/argmax_valid: unsigned argmax of the
// streamed vector, ties to the lower index, pulsed one cycle after the final transfer.
module softmax_serializer
  import softmax_pkg::*;
#(
  parameter int NUM = DEF_NUM,
  parameter int LEN = DEF_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM*LEN-1:0]      in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LEN-1:0]          out_data,
  output logic [idx_w(NUM)-1:0]   out_idx,
`ifdef SOFTMAX_SER_ARGMAX_EN
  output logic [idx_w(NUM)-1:0]   argmax_idx,
  output logic                    argmax_valid,
`endif
  output logic                    out_last
);
  localparam int IW = idx_w(NUM);
  localparam logic [IW-1:0] LAST = IW'(NUM - 1);
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic [NUM*LEN-1:0] vec;
  logic cap, xfer;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == SEND;
    out_idx   = idx;
    out_data  = vec[idx*LEN +: LEN];
    out_last  = out_valid && idx == LAST;
    cap       = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    state_nxt = cap ? SEND : (xfer && out_last) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      vec   <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        vec <= in;
        idx <= '0;
      end else if (xfer && !out_last) idx <= idx + 1'b1;
    end
`ifdef SOFTMAX_SER_ARGMAX_EN
  // strict compare keeps the earlier index on ties; element 0 always seeds the tracker
  logic [LEN-1:0] best_val;
  logic [IW-1:0] best_idx;
  logic take;
  always_comb take = idx == '0 || out_data > best_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      best_val     <= '0;
      best_idx     <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= xfer && out_last;
      if (cap) argmax_idx <= '0;
      else if (xfer) begin
        if (take) begin
          best_val <= out_data;
          best_idx <= idx;
        end
        if (out_last) argmax_idx <= take ? idx : best_idx;
      end
    end
`endif
endmodule

// File: tb/tb_softmax_serializer.sv
// tb_softmax_serializer: scoreboard bench for softmax_serializer (argmax checks when SOFTMAX_SER_ARGMAX_EN is defined)
module tb_softmax_serializer;
  localparam int NUM = 18;
  localparam int LEN = 16;
  localparam int IW = 5;
  typedef struct packed {
    logic [LEN-1:0] d;
    logic [IW-1:0] i;
    logic l;
  } exp_t;
  exp_t q[$];
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [NUM*LEN-1:0] in_vec = '0;
  logic in_ready, out_valid, out_last;
  logic [LEN-1:0] out_data;
  logic [IW-1:0] out_idx;
`ifdef SOFTMAX_SER_ARGMAX_EN
  logic [IW-1:0] argmax_idx;
  logic argmax_valid;
`endif
  int n_chk = 0, n_pass = 0, xfers = 0;

  softmax_serializer #(.NUM(NUM), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
`ifdef SOFTMAX_SER_ARGMAX_EN
    .argmax_idx(argmax_idx), .argmax_valid(argmax_valid),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NUM*LEN-1:0] ramp(input int base, input int step);
    logic [NUM*LEN-1:0] r;
    for (int k = 0; k < NUM; k++) r[k*LEN +: LEN] = LEN'(base + k * step);
    return r;
  endfunction

  task automatic push_vec(input logic [NUM*LEN-1:0] v);
    for (int k = 0; k < NUM; k++) q.push_back('{v[k*LEN +: LEN], IW'(k), k == NUM - 1});
  endtask

  task automatic offer(input logic [NUM*LEN-1:0] v);
    chk("offer_ready", in_ready, 1);
    in_vec = v;
    in_valid = 1;
    push_vec(v);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    for (int c = 0; c < budget && q.size() != 0; c++) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
    out_ready = 1;
  endtask

  task automatic wait_idx(input int n);
    for (int c = 0; c < 40 && !(out_valid && out_idx == IW'(n)); c++) begin
      @(posedge clk); #1;
    end
    chk("reach_idx", out_idx, n);
  endtask

  // every presented element is checked against the scoreboard head; popped only on transfer
  always @(negedge clk)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_valid", out_valid, 0);
      else begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", out_idx, q[0].i);
        chk("out_last", out_last, q[0].l);
        chk("in_ready_send", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NUM*LEN-1:0] v;
    int seen;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    @(posedge clk); #1;
    // scenario 1: straight stream
    chk("idle_valid", out_valid, 0);
    offer(ramp(0, 8));
    chk("lat_valid", out_valid, 1);
    chk("lat_idx", out_idx, 0);
    drain(40, 0);
    chk("xfers_s1", xfers, 18);
    chk("idle_after_valid", out_valid, 0);
    chk("idle_after_ready", in_ready, 1);
    // scenario 2: toggling back-pressure
    xfers = 0;
    offer(ramp(0, 8));
    drain(80, 1);
    chk("xfers_s2", xfers, 18);
    @(posedge clk); #1;
    // scenario 3: in_valid during SEND is ignored
    offer(ramp(0, 8));
    wait_idx(5);
    in_vec = ramp(1000, 1);
    in_valid = 1;
    repeat (3) begin
      chk("in_ready_s3", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain(40, 0);
    @(posedge clk); #1;
    // scenario 4: async reset mid-vector
    offer(ramp(0, 8));
    wait_idx(9);
    #1 rst = 1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_idx", out_idx, 0);
    chk("abort_data", out_data, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    repeat (25) begin
      seen += int'(out_valid);
      @(posedge clk); #1;
    end
    chk("no_residual", seen, 0);
    chk("post_abort_ready", in_ready, 1);
    // scenario 5: back-to-back vectors, one idle cycle between
    offer(ramp(0, 8));
    wait_idx(17);
    chk("b2b_last", out_last, 1);
    v = ramp(5, 3);
    in_vec = v;
    in_valid = 1;
    push_vec(v);
    @(posedge clk); #1;
    chk("gap_idle_valid", out_valid, 0);
    chk("gap_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("gap_first_valid", out_valid, 1);
    chk("gap_first_idx", out_idx, 0);
    drain(40, 0);
`ifdef SOFTMAX_SER_ARGMAX_EN
    // scenario 6: tied maxima at 3 and 11
    @(posedge clk); #1;
    v = ramp(1, 1);
    v[3*LEN +: LEN] = '1;
    v[11*LEN +: LEN] = '1;
    offer(v);
    wait_idx(17);
    chk("amax_pre_valid", argmax_valid, 0);
    @(posedge clk); #1;
    chk("amax_valid", argmax_valid, 1);
    chk("amax_idx", argmax_idx, 3);
    @(posedge clk); #1;
    chk("amax_pulse_end", argmax_valid, 0);
    chk("amax_hold", argmax_idx, 3);
    drain(10, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
